// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the integer register file and its scoreboard.
package regfile_scoreboard_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int X0_IDX   = 0;

   // True for an index that holds real state: not the hardwired zero register and inside the array.
   function automatic logic is_live_reg(input int idx, input int nreg);
      return (idx != X0_IDX) && (idx < nreg);
   endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bus of the register file: read ports, write ports, issue, flush, busy map.
interface regfile_scoreboard_if #(
   parameter int XLEN   = regfile_scoreboard_pkg::XLEN_DEF,
   parameter int NREG   = regfile_scoreboard_pkg::NREG_DEF,
   parameter int NREAD  = 2,
   parameter int NWRITE = 2
);
   localparam int AW = $clog2(NREG);

   logic [NREAD-1:0]       re_i;
   logic [NREAD*AW-1:0]    raddr_i;
   logic [NREAD*XLEN-1:0]  rdata_o;
   logic [NREAD-1:0]       rrdy_o;
   logic [NWRITE-1:0]      we_i;
   logic [NWRITE*AW-1:0]   waddr_i;
   logic [NWRITE*XLEN-1:0] wdata_i;
   logic                   iss_i;
   logic [AW-1:0]          iss_rd_i;
   logic                   flush_i;
   logic [NREG-1:0]        busy_o;

   modport master (
      output re_i, raddr_i, we_i, waddr_i, wdata_i, iss_i, iss_rd_i, flush_i,
      input  rdata_o, rrdy_o, busy_o
   );

   modport slave (
      input  re_i, raddr_i, we_i, waddr_i, wdata_i, iss_i, iss_rd_i, flush_i,
      output rdata_o, rrdy_o, busy_o
   );

endinterface

// File: rtl/regfile_scoreboard_busy_table.sv
// Per-register busy scoreboard: writeback clears, long-latency issue sets, flush wipes everything.
module regfile_scoreboard_busy_table
   import regfile_scoreboard_pkg::*;
#(
   parameter int NREG   = NREG_DEF,
   parameter int NWRITE = 2,
   parameter int AW     = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iss_i,
   input  logic [AW-1:0]        iss_rd_i,
   input  logic [NWRITE-1:0]    we_i,
   input  logic [NWRITE*AW-1:0] waddr_i,
   input  logic                 flush_i,
   output logic [NREG-1:0]      busy_o
);

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_next;

   // Next busy map: clear, then set (a new writer outranks the old writeback), then flush overrides all.
   always_comb begin
      w_busy_next = r_busy;
      w_busy_next[X0_IDX] = 1'b0;
      for (int r = 1; r < NREG; r++) begin
         for (int p = 0; p < NWRITE; p++) begin
            if (we_i[p] && (int'(waddr_i[p*AW +: AW]) == r)) begin
               w_busy_next[r] = 1'b0;
            end
         end
         if (iss_i && (int'(iss_rd_i) == r)) begin
            w_busy_next[r] = 1'b1;
         end
         if (flush_i) begin
            w_busy_next[r] = 1'b0;
         end
      end
   end

   // Scoreboard state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   assign busy_o = r_busy;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard for operand readiness.
module regfile_scoreboard
   import regfile_scoreboard_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREG   = NREG_DEF,
   parameter int NREAD  = 2,
   parameter int NWRITE = 2
) (
   input  logic                clk,
   input  logic                rst,
   regfile_scoreboard_if.slave bus
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0]   r_regs [NREG];
   logic [NWRITE-1:0] w_wvalid;
   logic [NREG-1:0]   w_wen;
   logic [XLEN-1:0]   w_wdat [NREG];
   logic [NREG-1:0]   w_busy;

   // A write port only counts when it targets a real register; x0 and out-of-range writes vanish.
   for (genvar gi = 0; gi < NWRITE; gi++) begin : g_wvalid
      assign w_wvalid[gi] = bus.we_i[gi] && is_live_reg(int'(bus.waddr_i[gi*AW +: AW]), NREG);
   end

   // Per-register write select; scanning ports upward lets the highest-index port win a collision.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         w_wen[r]  = 1'b0;
         w_wdat[r] = '0;
         for (int p = 0; p < NWRITE; p++) begin
            if (w_wvalid[p] && (int'(bus.waddr_i[p*AW +: AW]) == r)) begin
               w_wen[r]  = 1'b1;
               w_wdat[r] = bus.wdata_i[p*XLEN +: XLEN];
            end
         end
      end
   end

   // Register storage; reset wipes contents and discards this cycle's writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            r_regs[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (w_wen[r]) begin
               r_regs[r] <= w_wdat[r];
            end
         end
      end
   end

   regfile_scoreboard_busy_table #(
      .NREG   (NREG),
      .NWRITE (NWRITE),
      .AW     (AW)
   ) u_busy (
      .clk      (clk),
      .rst      (rst),
      .iss_i    (bus.iss_i),
      .iss_rd_i (bus.iss_rd_i),
      .we_i     (bus.we_i),
      .waddr_i  (bus.waddr_i),
      .flush_i  (bus.flush_i),
      .busy_o   (w_busy)
   );

   assign bus.busy_o = w_busy;

   for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      logic            w_rdy;

      assign w_addr = bus.raddr_i[gi*AW +: AW];

      // Read mux: a same-cycle write bypasses the array and makes the operand ready regardless of busy.
      always_comb begin
         w_data = '0;
         w_rdy  = 1'b1;
         if (rst) begin
            w_rdy = 1'b0;
         end else if (bus.re_i[gi] && is_live_reg(int'(w_addr), NREG)) begin
            w_data = r_regs[w_addr];
            w_rdy  = !w_busy[w_addr];
            for (int p = 0; p < NWRITE; p++) begin
               if (w_wvalid[p] && (bus.waddr_i[p*AW +: AW] == w_addr)) begin
                  w_data = bus.wdata_i[p*XLEN +: XLEN];
                  w_rdy  = 1'b1;
               end
            end
         end
      end

      assign bus.rdata_o[gi*XLEN +: XLEN] = w_data;
      assign bus.rrdy_o[gi]               = w_rdy;
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: expected values go into a queue as stimulus is driven, popped when the DUT answers.
module tb_regfile_scoreboard;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;
   logic [63:0] sb_q[$];
   logic [63:0] exp;

   logic [31:0] m_regs [32];
   logic [31:0] m_busy;

   regfile_scoreboard_if #(.XLEN(32), .NREG(32), .NREAD(2), .NWRITE(2)) bus ();

   regfile_scoreboard #(.XLEN(32), .NREG(32), .NREAD(2), .NWRITE(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      bus.re_i = '0; bus.raddr_i = '0; bus.we_i = '0; bus.waddr_i = '0; bus.wdata_i = '0;
      bus.iss_i = 1'b0; bus.iss_rd_i = '0; bus.flush_i = 1'b0;
   endtask

   task automatic rd(input int p, input int a);
      bus.re_i[p] = 1'b1;
      bus.raddr_i[p*5 +: 5] = 5'(a);
   endtask

   task automatic wr(input int p, input int a, input logic [31:0] d);
      bus.we_i[p] = 1'b1;
      bus.waddr_i[p*5 +: 5] = 5'(a);
      bus.wdata_i[p*32 +: 32] = d;
   endtask

   task automatic iss(input int a);
      bus.iss_i = 1'b1;
      bus.iss_rd_i = 5'(a);
   endtask

   task automatic test_reset();
      rst = 1'b1; idle();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      sb_q.push_back(64'h0); sb_q.push_back(64'h3);
      exp = sb_q.pop_front(); n_checks++; if (bus.busy_o !== exp[31:0]) begin n_fails++; $display("FAIL reset_busy got %h want %h", bus.busy_o, exp[31:0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.rrdy_o !== exp[1:0]) begin n_fails++; $display("FAIL reset_rrdy got %b want %b", bus.rrdy_o, exp[1:0]); end
      @(negedge clk); idle(); wr(0, 5, 32'hDEAD);
      @(negedge clk); idle(); rd(0, 5);
      #1; sb_q.push_back(64'hDEAD);
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[31:0] !== exp[31:0]) begin n_fails++; $display("FAIL preload_x5 got %h want %h", bus.rdata_o[31:0], exp[31:0]); end
      @(negedge clk); rst = 1'b1; idle(); rd(0, 5); wr(1, 6, 32'h66);
      #1; sb_q.push_back(64'h0); sb_q.push_back(64'h0);
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[31:0] !== exp[31:0]) begin n_fails++; $display("FAIL in_reset_rdata got %h want %h", bus.rdata_o[31:0], exp[31:0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.rrdy_o !== exp[1:0]) begin n_fails++; $display("FAIL in_reset_rrdy got %b want %b", bus.rrdy_o, exp[1:0]); end
      @(negedge clk); rst = 1'b0; idle(); rd(0, 5); rd(1, 6);
      #1; sb_q.push_back(64'h0); sb_q.push_back(64'h0); sb_q.push_back(64'h3); sb_q.push_back(64'h0);
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[31:0] !== exp[31:0]) begin n_fails++; $display("FAIL post_reset_x5 got %h want %h", bus.rdata_o[31:0], exp[31:0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[63:32] !== exp[31:0]) begin n_fails++; $display("FAIL dropped_write_x6 got %h want %h", bus.rdata_o[63:32], exp[31:0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.rrdy_o !== exp[1:0]) begin n_fails++; $display("FAIL post_reset_rrdy got %b want %b", bus.rrdy_o, exp[1:0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.busy_o !== exp[31:0]) begin n_fails++; $display("FAIL post_reset_busy got %h want %h", bus.busy_o, exp[31:0]); end
      $display("txn reset done");
   endtask

   task automatic test_bypass();
      @(negedge clk); idle(); wr(0, 7, 32'h1234); rd(1, 7);
      #1; sb_q.push_back(64'h1234); sb_q.push_back(64'h1);
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[63:32] !== exp[31:0]) begin n_fails++; $display("FAIL bypass_rdata got %h want %h", bus.rdata_o[63:32], exp[31:0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.rrdy_o[1] !== exp[0]) begin n_fails++; $display("FAIL bypass_rrdy got %b want %b", bus.rrdy_o[1], exp[0]); end
      @(negedge clk); idle(); rd(1, 7);
      #1; sb_q.push_back(64'h1234);
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[63:32] !== exp[31:0]) begin n_fails++; $display("FAIL array_x7 got %h want %h", bus.rdata_o[63:32], exp[31:0]); end
      $display("txn bypass x7 done");
   endtask

   task automatic test_conflict();
      @(negedge clk); idle(); wr(0, 3, 32'hAAAA); wr(1, 3, 32'hBBBB); rd(0, 3);
      #1; sb_q.push_back(64'hBBBB);
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[31:0] !== exp[31:0]) begin n_fails++; $display("FAIL conflict_bypass got %h want %h", bus.rdata_o[31:0], exp[31:0]); end
      @(negedge clk); idle(); rd(0, 3);
      #1; sb_q.push_back(64'hBBBB);
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[31:0] !== exp[31:0]) begin n_fails++; $display("FAIL conflict_array got %h want %h", bus.rdata_o[31:0], exp[31:0]); end
      $display("txn write conflict x3 done");
   endtask

   task automatic test_scoreboard();
      @(negedge clk); idle(); iss(9); rd(0, 9);
      #1; sb_q.push_back(64'h1);
      exp = sb_q.pop_front(); n_checks++; if (bus.rrdy_o[0] !== exp[0]) begin n_fails++; $display("FAIL issue_cycle_rrdy got %b want %b", bus.rrdy_o[0], exp[0]); end
      @(negedge clk); idle(); rd(0, 9);
      #1; sb_q.push_back(64'h0); sb_q.push_back(64'h200);
      exp = sb_q.pop_front(); n_checks++; if (bus.rrdy_o[0] !== exp[0]) begin n_fails++; $display("FAIL busy_rrdy got %b want %b", bus.rrdy_o[0], exp[0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.busy_o !== exp[31:0]) begin n_fails++; $display("FAIL busy9_map got %h want %h", bus.busy_o, exp[31:0]); end
      @(negedge clk); idle(); rd(0, 9); wr(1, 9, 32'h55);
      #1; sb_q.push_back(64'h1); sb_q.push_back(64'h55);
      exp = sb_q.pop_front(); n_checks++; if (bus.rrdy_o[0] !== exp[0]) begin n_fails++; $display("FAIL wb_rrdy got %b want %b", bus.rrdy_o[0], exp[0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[31:0] !== exp[31:0]) begin n_fails++; $display("FAIL wb_rdata got %h want %h", bus.rdata_o[31:0], exp[31:0]); end
      @(negedge clk); idle(); rd(0, 9);
      #1; sb_q.push_back(64'h0); sb_q.push_back(64'h55);
      exp = sb_q.pop_front(); n_checks++; if (bus.busy_o !== exp[31:0]) begin n_fails++; $display("FAIL busy9_clear got %h want %h", bus.busy_o, exp[31:0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[31:0] !== exp[31:0]) begin n_fails++; $display("FAIL x9_array got %h want %h", bus.rdata_o[31:0], exp[31:0]); end
      $display("txn scoreboard x9 done");
   endtask

   task automatic test_collision();
      @(negedge clk); idle(); iss(4);
      @(negedge clk); idle(); iss(4); wr(0, 4, 32'h77);
      @(negedge clk); idle(); rd(0, 4);
      #1; sb_q.push_back(64'h10); sb_q.push_back(64'h0); sb_q.push_back(64'h77);
      exp = sb_q.pop_front(); n_checks++; if (bus.busy_o !== exp[31:0]) begin n_fails++; $display("FAIL set_beats_clear got %h want %h", bus.busy_o, exp[31:0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.rrdy_o[0] !== exp[0]) begin n_fails++; $display("FAIL x4_pending got %b want %b", bus.rrdy_o[0], exp[0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[31:0] !== exp[31:0]) begin n_fails++; $display("FAIL x4_data got %h want %h", bus.rdata_o[31:0], exp[31:0]); end
      @(negedge clk); idle(); wr(1, 4, 32'h78);
      @(negedge clk); idle();
      #1; sb_q.push_back(64'h0);
      exp = sb_q.pop_front(); n_checks++; if (bus.busy_o !== exp[31:0]) begin n_fails++; $display("FAIL x4_cleared got %h want %h", bus.busy_o, exp[31:0]); end
      $display("txn set/clear collision x4 done");
   endtask

   task automatic test_x0_flush();
      @(negedge clk); idle(); iss(0); wr(0, 0, 32'hFFFF); rd(0, 0);
      #1; sb_q.push_back(64'h0); sb_q.push_back(64'h1);
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[31:0] !== exp[31:0]) begin n_fails++; $display("FAIL x0_bypass got %h want %h", bus.rdata_o[31:0], exp[31:0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.rrdy_o[0] !== exp[0]) begin n_fails++; $display("FAIL x0_rrdy got %b want %b", bus.rrdy_o[0], exp[0]); end
      @(negedge clk); idle(); rd(1, 0);
      #1; sb_q.push_back(64'h0); sb_q.push_back(64'h0);
      exp = sb_q.pop_front(); n_checks++; if (bus.rdata_o[63:32] !== exp[31:0]) begin n_fails++; $display("FAIL x0_array got %h want %h", bus.rdata_o[63:32], exp[31:0]); end
      exp = sb_q.pop_front(); n_checks++; if (bus.busy_o !== exp[31:0]) begin n_fails++; $display("FAIL x0_busy got %h want %h", bus.busy_o, exp[31:0]); end
      @(negedge clk); idle(); iss(2);
      @(negedge clk); idle(); iss(8);
      @(negedge clk); idle(); bus.flush_i = 1'b1; iss(5);
      #1; sb_q.push_back(64'h104);
      exp = sb_q.pop_front(); n_checks++; if (bus.busy_o !== exp[31:0]) begin n_fails++; $display("FAIL pre_flush_busy got %h want %h", bus.busy_o, exp[31:0]); end
      @(negedge clk); idle();
      #1; sb_q.push_back(64'h0);
      exp = sb_q.pop_front(); n_checks++; if (bus.busy_o !== exp[31:0]) begin n_fails++; $display("FAIL flush_busy got %h want %h", bus.busy_o, exp[31:0]); end
      $display("txn x0 and flush done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] nb;
      logic [31:0] ed;
      logic        er;
      int          a;
      @(negedge clk); rst = 1'b1; idle();
      @(negedge clk); rst = 1'b0;
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_busy = '0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk); idle();
         for (int p = 0; p < 2; p++) begin
            if ($urandom_range(0, 3) != 0) rd(p, $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) wr(p, $urandom_range(0, 7), $urandom);
         end
         if ($urandom_range(0, 2) == 0) iss($urandom_range(0, 7));
         bus.flush_i = ($urandom_range(0, 9) == 0);
         for (int p = 0; p < 2; p++) begin
            a = int'(bus.raddr_i[p*5 +: 5]);
            ed = '0; er = 1'b1;
            if (bus.re_i[p] && a != 0) begin
               ed = m_regs[a]; er = !m_busy[a];
               for (int q = 0; q < 2; q++)
                  if (bus.we_i[q] && int'(bus.waddr_i[q*5 +: 5]) == a) begin ed = bus.wdata_i[q*32 +: 32]; er = 1'b1; end
            end
            sb_q.push_back({31'b0, er, ed});
         end
         sb_q.push_back({32'b0, m_busy});
         #1;
         for (int p = 0; p < 2; p++) begin
            exp = sb_q.pop_front(); n_checks++;
            if ({bus.rrdy_o[p], bus.rdata_o[p*32 +: 32]} !== exp[32:0]) begin
               n_fails++; $display("FAIL b2b_read t=%0d port=%0d got %b/%h want %b/%h", t, p, bus.rrdy_o[p], bus.rdata_o[p*32 +: 32], exp[32], exp[31:0]);
            end
         end
         exp = sb_q.pop_front(); n_checks++;
         if (bus.busy_o !== exp[31:0]) begin n_fails++; $display("FAIL b2b_busy t=%0d got %h want %h", t, bus.busy_o, exp[31:0]); end
         $display("txn b2b %0d re=%b we=%b iss=%b flush=%b", t, bus.re_i, bus.we_i, bus.iss_i, bus.flush_i);
         nb = m_busy;
         for (int q = 0; q < 2; q++) begin
            a = int'(bus.waddr_i[q*5 +: 5]);
            if (bus.we_i[q] && a != 0) begin m_regs[a] = bus.wdata_i[q*32 +: 32]; nb[a] = 1'b0; end
         end
         if (bus.iss_i && bus.iss_rd_i != 0) nb[bus.iss_rd_i] = 1'b1;
         if (bus.flush_i) nb = '0;
         m_busy = nb;
      end
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst = 1'b1;
      idle();
      test_reset();
      test_bypass();
      test_conflict();
      test_scoreboard();
      test_collision();
      test_x0_flush();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
